// File: rtl/legv8_pkg.sv
// legv8_pkg: immediate format classes, matched opcodes and default widths
package legv8_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int RAW_W = 26;
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_D     = 3'd2,
    FMT_B     = 3'd3,
    FMT_CB    = 3'd4,
    FMT_IW    = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_D_100 = 11'b11111000100;
  localparam logic [10:0] OP_D_110 = 11'b11111000110;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OP_MOVK  = 9'b111100101;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
  localparam logic [10:0] OP_LSL   = 11'b11010011011;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: in channel (valid/ready/instr/pc) and out channel (valid/ready/fmt/imm/target); slave = generator side
interface imm_gen_pipe_if import legv8_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_fmt;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_target;
  modport master (output in_valid, in_instr, in_pc, out_ready,
                  input in_ready, out_valid, out_fmt, out_imm, out_target);
  modport slave (input in_valid, in_instr, in_pc, out_ready,
                 output in_ready, out_valid, out_fmt, out_imm, out_target);
endinterface

// File: rtl/imm_classify.sv
// imm_classify: instr -> format class, right-aligned unextended immediate field, IW halfword select
module imm_classify import legv8_pkg::*; (
  input  logic [31:0]      instr,
  output fmt_e             fmt,
  output logic [RAW_W-1:0] raw,
  output logic [1:0]       hw
);
  assign fmt = (instr[31:26] == OP_B || instr[31:26] == OP_BL) ? FMT_B :
               (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ || instr[31:24] == OP_BCOND) ? FMT_CB :
               (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR ||
                instr[31:21] == OP_D_100 || instr[31:21] == OP_D_110) ? FMT_D :
               (instr[31:23] == OP_MOVZ || instr[31:23] == OP_MOVK) ? FMT_IW :
               (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI ||
                instr[31:22] == OP_ANDI || instr[31:22] == OP_ORRI) ? FMT_I :
               (instr[31:21] == OP_LSL || instr[31:21] == OP_LSR) ? FMT_SHAMT : FMT_NONE;
  assign raw = fmt == FMT_B     ? instr[25:0] :
               fmt == FMT_CB    ? RAW_W'(instr[23:5]) :
               fmt == FMT_D     ? RAW_W'(instr[20:12]) :
               fmt == FMT_IW    ? RAW_W'(instr[20:5]) :
               fmt == FMT_I     ? RAW_W'(instr[21:10]) :
               fmt == FMT_SHAMT ? RAW_W'(instr[15:10]) : '0;
  assign hw = fmt == FMT_IW ? instr[22:21] : 2'b00;
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: 2-stage LEGv8 immediate/branch-target generator; clk, reset, flush, bus (imm_gen_pipe_if.slave)
module imm_gen_pipe import legv8_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BR_SHIFT = 2
) (
  input logic          clk,
  input logic          reset,
  input logic          flush,
  imm_gen_pipe_if.slave bus
);
  fmt_e              c_fmt, s1_fmt, s2_fmt;
  logic [RAW_W-1:0]  c_raw, s1_raw;
  logic [1:0]        c_hw, s1_hw;
  logic [DATA_W-1:0] s1_pc, imm, target, s2_imm, s2_target;
  logic              s1_valid, s2_valid, s2_load, in_ready;
  imm_classify u_cls (.instr(bus.in_instr), .fmt(c_fmt), .raw(c_raw), .hw(c_hw));
  assign s2_load        = !s2_valid || bus.out_ready;
  assign in_ready       = !flush && (!s1_valid || s2_load);
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_valid;
  assign bus.out_fmt    = s2_fmt;
  assign bus.out_imm    = s2_imm;
  assign bus.out_target = s2_target;
  assign imm = s1_fmt == FMT_I     ? DATA_W'(s1_raw[11:0]) :
               s1_fmt == FMT_D     ? {{(DATA_W-9){s1_raw[8]}}, s1_raw[8:0]} :
               s1_fmt == FMT_B     ? {{(DATA_W-26){s1_raw[25]}}, s1_raw} :
               s1_fmt == FMT_CB    ? {{(DATA_W-19){s1_raw[18]}}, s1_raw[18:0]} :
               s1_fmt == FMT_IW    ? DATA_W'(s1_raw[15:0]) << {s1_hw, 4'b0000} :
               s1_fmt == FMT_SHAMT ? DATA_W'(s1_raw[5:0]) : '0;
  assign target = (s1_fmt == FMT_B || s1_fmt == FMT_CB) ? s1_pc + (imm << BR_SHIFT) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= FMT_NONE;
      s1_raw    <= '0;
      s1_hw     <= '0;
      s1_pc     <= '0;
      s2_valid  <= 1'b0;
      s2_fmt    <= FMT_NONE;
      s2_imm    <= '0;
      s2_target <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= bus.in_valid;
      if (in_ready && bus.in_valid) begin
        s1_fmt <= c_fmt;
        s1_raw <= c_raw;
        s1_hw  <= c_hw;
        s1_pc  <= bus.in_pc;
      end
      if (s2_load) s2_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        s2_fmt    <= s1_fmt;
        s2_imm    <= imm;
        s2_target <= target;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;
  localparam int W = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int checks = 0;
  int errors = 0;
  imm_gen_pipe_if #(.DATA_W(W)) bus ();
  imm_gen_pipe #(.DATA_W(W), .BR_SHIFT(2)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] i, input logic [W-1:0] pc);
    bus.in_valid = v;
    bus.in_instr = i;
    bus.in_pc    = pc;
  endtask
  task automatic test_reset();
    drive(1'b0, 32'h0, '0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_imm !== 64'h0) begin errors++; $display("FAIL rst_imm got %h want 0", bus.out_imm); end
    checks++; if (bus.out_target !== 64'h0) begin errors++; $display("FAIL rst_target got %h want 0", bus.out_target); end
    checks++; if (bus.out_fmt !== 3'd0) begin errors++; $display("FAIL rst_fmt got %0d want 0", bus.out_fmt); end
    reset = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
  endtask
  task automatic test_branch();
    drive(1'b1, 32'h17FFFFFF, 64'h1000);
    tick();
    drive(1'b0, 32'h0, '0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b_early got %b want 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_fmt !== 3'd3) begin errors++; $display("FAIL b_fmt got %0d want 3", bus.out_fmt); end
    checks++; if (bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL b_imm got %h want ffffffffffffffff", bus.out_imm); end
    checks++; if (bus.out_target !== 64'h0FFC) begin errors++; $display("FAIL b_target got %h want ffc", bus.out_target); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b_drain got %b want 0", bus.out_valid); end
  endtask
  task automatic test_back_to_back();
    drive(1'b1, 32'hB4000080, 64'h40);
    tick();
    drive(1'b1, 32'hF85F8000, 64'h44);
    tick();
    drive(1'b0, 32'h0, '0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_fmt !== 3'd4) begin errors++; $display("FAIL cb_fmt got v=%b f=%0d want v=1 f=4", bus.out_valid, bus.out_fmt); end
    checks++; if (bus.out_imm !== 64'h4) begin errors++; $display("FAIL cb_imm got %h want 4", bus.out_imm); end
    checks++; if (bus.out_target !== 64'h50) begin errors++; $display("FAIL cb_target got %h want 50", bus.out_target); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_fmt !== 3'd2) begin errors++; $display("FAIL d_fmt got v=%b f=%0d want v=1 f=2", bus.out_valid, bus.out_fmt); end
    checks++; if (bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL d_imm got %h want fffffffffffffff8", bus.out_imm); end
    checks++; if (bus.out_target !== 64'h0) begin errors++; $display("FAIL d_target got %h want 0", bus.out_target); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask
  task automatic test_formats();
    logic [31:0] ins [4] = '{32'hD2F7DDE0, 32'h913FFC00, 32'hD3601400, 32'h8B020020};
    logic [2:0]  fmt [4] = '{3'd5, 3'd1, 3'd6, 3'd0};
    logic [W-1:0] imm [4] = '{64'hBEEF_0000_0000_0000, 64'hFFF, 64'h5, 64'h0};
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, i < 4 ? ins[i] : 32'h0, 64'h100);
      tick();
      if (i >= 1) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_fmt !== fmt[i-1]) begin errors++; $display("FAIL fmt_%0d got v=%b f=%0d want v=1 f=%0d", i-1, bus.out_valid, bus.out_fmt, fmt[i-1]); end
        checks++; if (bus.out_imm !== imm[i-1] || bus.out_target !== 64'h0) begin errors++; $display("FAIL imm_%0d got %h/%h want %h/0", i-1, bus.out_imm, bus.out_target, imm[i-1]); end
      end
    end
    drive(1'b0, 32'h0, '0);
    tick();
  endtask
  task automatic test_stall();
    logic [31:0] ins [4] = '{32'h91000400, 32'h91000800, 32'h91000C00, 32'h91001000};
    int idx = 0;
    int got = 0;
    logic acc;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(idx < 4, ins[idx < 4 ? idx : 0], 64'h0);
      #1;
      acc = bus.in_ready && bus.in_valid;
      tick();
      if (acc) idx++;
      if (c >= 1) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_fmt !== 3'd1 || bus.out_imm !== 64'h1) begin errors++; $display("FAIL stall_hold_%0d got v=%b f=%0d imm=%h want v=1 f=1 imm=1", c, bus.out_valid, bus.out_fmt, bus.out_imm); end
      end
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL stall_accepts got %0d want 2", idx); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      drive(idx < 4, ins[idx < 4 ? idx : 0], 64'h0);
      #1;
      acc = bus.in_ready && bus.in_valid;
      if (bus.out_valid) begin
        checks++; if (bus.out_imm !== W'(got + 1)) begin errors++; $display("FAIL stall_order_%0d got %h want %0d", got, bus.out_imm, got + 1); end
        got++;
      end
      tick();
      if (acc) idx++;
    end
    drive(1'b0, 32'h0, '0);
    checks++; if (got != 4 || idx != 4) begin errors++; $display("FAIL stall_delivered got %0d/%0d want 4/4", got, idx); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_dup got %b want 0", bus.out_valid); end
  endtask
  task automatic test_flush();
    logic seen = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h91000400, 64'h0);
    tick();
    drive(1'b1, 32'h91000800, 64'h0);
    tick();
    drive(1'b1, 32'h91000C00, 64'h0);
    flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, '0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_leak got %b want 0", seen); end
  endtask
  task automatic test_reset_mid();
    logic seen = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h17FFFFFF, 64'h1000);
    tick();
    drive(1'b1, 32'hB4000080, 64'h40);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_target !== 64'h0FFC) begin errors++; $display("FAIL rmid_pre got v=%b t=%h want v=1 t=ffc", bus.out_valid, bus.out_target); end
    reset = 1'b1;
    flush = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_fmt !== 3'd0) begin errors++; $display("FAIL rmid_vf got v=%b f=%0d want v=0 f=0", bus.out_valid, bus.out_fmt); end
    checks++; if (bus.out_imm !== 64'h0 || bus.out_target !== 64'h0) begin errors++; $display("FAIL rmid_data got %h/%h want 0/0", bus.out_imm, bus.out_target); end
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, '0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_leak got %b want 0", seen); end
  endtask
  initial begin
    test_reset();
    test_branch();
    test_back_to_back();
    test_formats();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
